// File: rtl/core_fetch_ctrl.sv
// PC sequencer and single-outstanding instruction-fetch controller with branch redirect and flush.
// Optional FETCH_MISALIGN_CHECK_EN: reject redirects to non-word-aligned targets and pulse misaligned_o.
module core_fetch_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  input  logic                  stall_i,
  input  logic                  br_valid_i,
  input  logic                  br_taken_i,
  input  logic [DATA_WIDTH-1:0] br_target_i,
  output logic                  flush_o,
  output logic                  misaligned_o
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, VALID} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                  kill_q, kill_d;
  logic                  valid_q, valid_d;
  logic                  flush_q;
  logic                  taken, bad_tgt, redir;
  logic [DATA_WIDTH-1:0] tgt;

  assign taken = br_valid_i & br_taken_i & (state_q != BOOT);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q;
  assign bad_tgt = taken & (|br_target_i[1:0]);
  assign tgt     = br_target_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= bad_tgt;
  end
  assign misaligned_o = mis_q;
`else
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^br_target_i[1:0];
  assign bad_tgt         = 1'b0;
  assign tgt             = {br_target_i[DATA_WIDTH-1:2], 2'b00};
  assign misaligned_o    = 1'b0;
`endif

  assign redir = taken & ~bad_tgt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_gnt_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + DATA_WIDTH'(4);
          kill_d     = redir;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          kill_d  = 1'b0;
          state_d = REQ;
          if (!kill_q && !redir) begin
            instr_d  = imem_rdata_i;
            pc_out_d = fetch_pc_q;
            valid_d  = 1'b1;
            state_d  = VALID;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      VALID: begin
        if (redir || !stall_i) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
    // A taken redirect overrides the sequential +4 and squashes anything held.
    if (redir) begin
      pc_d    = tgt;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= BOOT_ADDR;
      kill_q   <= 1'b0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= BOOT_ADDR;
    end else begin
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      valid_q  <= valid_d;
      flush_q  <= redir;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fetch_pc_q <= fetch_pc_d;
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign flush_o       = flush_q;
endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Bench for core_fetch_ctrl: instruction-memory responder, flag-based reference model and directed scenarios.
module tb_core_fetch_ctrl;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        flush;
  logic        misaligned;

  bit          gnt_en = 1'b1;
  int          lat = 1;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  assign gnt = gnt_en;

  core_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc),
    .stall_i(stall), .br_valid_i(br_valid), .br_taken_i(br_taken),
    .br_target_i(br_target), .flush_o(flush), .misaligned_o(misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  // Memory: grants whenever gnt_en is set, returns data lat cycles after a grant.
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  always begin
    @(negedge clk); #2;
    rvalid = 1'b0;
    if (rst) pend = 1'b0;
    else if (pend) begin
      if (cnt == 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(paddr);
        pend   = 1'b0;
      end else cnt--;
    end
    if (!rst && imem_req && gnt_en) begin
      pend  = 1'b1;
      paddr = imem_addr;
      cnt   = lat - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: flags for "booting", "fetch outstanding", "discard it", "instruction held".
  task automatic model_loop();
    bit          m_boot = 1'b1, m_out = 1'b0, m_disc = 1'b0, m_held = 1'b0;
    bit          m_fl = 1'b0, m_mis = 1'b0, take, bad;
    logic [31:0] m_pc = '0, m_oaddr = '0, m_hpc = '0, m_hins = '0, tgt;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_boot = 1'b1; m_out = 1'b0; m_disc = 1'b0; m_held = 1'b0;
        m_fl = 1'b0; m_mis = 1'b0; m_pc = '0;
      end else begin
        take = !m_boot && br_valid && br_taken;
        bad  = take && MIS_EN && (br_target[1:0] != 2'b00);
        if (bad) take = 1'b0;
        tgt  = MIS_EN ? br_target : (br_target & ~32'h3);
        m_fl  = take;
        m_mis = bad;
        if (m_boot) m_boot = 1'b0;
        else if (m_held) begin
          if (take || !stall) m_held = 1'b0;
        end else if (m_out) begin
          if (rvalid) begin
            if (!m_disc && !take) begin
              m_held = 1'b1; m_hpc = m_oaddr; m_hins = rdata;
            end
            m_out = 1'b0; m_disc = 1'b0;
          end else if (take) m_disc = 1'b1;
        end else if (gnt) begin
          m_out = 1'b1; m_oaddr = m_pc; m_disc = take; m_pc = m_pc + 32'd4;
        end
        if (take) m_pc = tgt;
      end
      check("m_req", 32'(imem_req), 32'(!m_boot && !m_out && !m_held && !rst));
      check("m_addr", imem_addr, m_pc);
      check("m_valid", 32'(instr_valid), 32'(m_held));
      check("m_flush", 32'(flush), 32'(m_fl));
      check("m_mis", 32'(misaligned), 32'(m_mis));
      if (m_held) begin
        check("m_pc_o", pc, m_hpc);
        check("m_instr", instr, m_hins);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(output int fl, output int vl);
    int n = 0;
    fl = 0; vl = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      tick(); n++;
      if (flush) fl++;
      if (instr_valid) vl++;
    end
    check("wait_req", 32'(imem_req), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t, input logic tk);
    br_valid = 1'b1; br_taken = tk; br_target = t;
    tick();
    br_valid = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    int fl, vl, n;
    fork model_loop(); join_none
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);

    // Boot: cycle 0 is BOOT, request at 1, data presented at 3.
    rst = 1'b0;
    tick();
    check("boot_req", 32'(imem_req), 32'd1);
    check("boot_addr0", imem_addr, 32'h0);
    tick(); tick();
    check("boot_valid", 32'(instr_valid), 32'd1);
    check("boot_pc", pc, 32'h0);
    check("boot_instr", instr, 32'h13);
    tick();
    check("boot_addr4", imem_addr, 32'h4);
    tick(); tick(); tick();
    check("boot_req8", 32'(imem_req), 32'd1);
    check("boot_addr8", imem_addr, 32'h8);

    // Stall for 5 cycles while holding pc 8.
    stall = 1'b1;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_pc", pc, 32'h8);
      check("stall_instr", instr, 32'h1B);
      check("stall_req", 32'(imem_req), 32'd0);
      if (i < 4) tick();
    end
    stall = 1'b0;
    lat = 3;
    tick();
    check("stall_rel_req", 32'(imem_req), 32'd1);
    check("stall_rel_addr", imem_addr, 32'hC);

    // Redirect while waiting for slow data.
    tick();
    redirect(32'h100, 1'b1);
    check("wr_flush", 32'(flush), 32'd1);
    wait_req(fl, vl);
    check("wr_flush_once", 32'(fl), 32'd0);
    check("wr_no_stale", 32'(vl), 32'd0);
    check("wr_addr", imem_addr, 32'h100);
    wait_valid();
    check("wr_pc", pc, 32'h100);
    check("wr_instr", instr, 32'h113);
    lat = 1;

    // Redirect colliding with grant.
    wait_req(fl, vl);
    redirect(32'h100, 1'b1);
    check("cg_flush", 32'(flush), 32'd1);
    wait_valid();
    check("cg_pc", pc, 32'h100);
    check("cg_instr", instr, 32'h113);

    // Redirect colliding with rvalid.
    wait_req(fl, vl);
    n = 0;
    while (!rvalid && n < 10) begin tick(); #2; n++; end
    redirect(32'h100, 1'b1);
    check("cr_flush", 32'(flush), 32'd1);
    check("cr_valid", 32'(instr_valid), 32'd0);
    wait_valid();
    check("cr_pc", pc, 32'h100);
    check("cr_instr", instr, 32'h113);

    // Redirect an ungranted request to the top word, then wrap.
    gnt_en = 1'b0;
    tick();
    redirect(32'hFFFF_FFFC, 1'b1);
    check("wp_addr", imem_addr, 32'hFFFF_FFFC);
    check("wp_flush", 32'(flush), 32'd1);
    gnt_en = 1'b1;
    wait_valid();
    check("wp_pc", pc, 32'hFFFF_FFFC);
    check("wp_instr", instr, 32'h0000_000F);
    gnt_en = 1'b0;
    tick();
    check("wp_wrap_addr", imem_addr, 32'h0);

    // Not-taken branch is a no-op.
    redirect(32'h300, 1'b0);
    check("nt_addr", imem_addr, 32'h0);
    check("nt_flush", 32'(flush), 32'd0);

    // Misaligned target.
    redirect(32'h102, 1'b1);
    check("ma_addr", imem_addr, MIS_EN ? 32'h0 : 32'h100);
    check("ma_flush", 32'(flush), MIS_EN ? 32'd0 : 32'd1);
    check("ma_mis", 32'(misaligned), MIS_EN ? 32'd1 : 32'd0);
    gnt_en = 1'b1;
    tick();
    check("ma_mis_clr", 32'(misaligned), 32'd0);
    wait_valid();
    check("ma_pc", pc, MIS_EN ? 32'h0 : 32'h100);

    // Reset in the middle of a fetch.
    wait_req(fl, vl);
    tick();
    rst = 1'b1;
    tick();
    check("mr_req", 32'(imem_req), 32'd0);
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_addr", imem_addr, 32'h0);
    rst = 1'b0;
    tick();
    check("mr_boot_req", 32'(imem_req), 32'd1);
    wait_valid();
    check("mr_pc", pc, 32'h0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_fetch_ctrl.md
# core_fetch_ctrl

Program-counter sequencer and instruction-fetch controller for the core. It owns the PC register and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It presents each fetched instruction with its PC to decode, and redirects the PC when execute resolves a taken branch or jump, flushing any wrong-path fetch. It replaces the free-running PC+4 path with a stall- and flush-aware sequencer.

## Interface
- `DATA_WIDTH`, 32, width of PC, addresses, targets and instruction word.
- `BOOT_ADDR`, 32'h0000_0000, PC value loaded on reset.

- `clk_i` input 1: core clock; all logic on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `imem_req_o` output 1: fetch request.
- `imem_addr_o` output DATA_WIDTH: fetch address, always equal to the internal PC.
- `imem_gnt_i` input 1: memory accepts the request this cycle.
- `imem_rvalid_i` input 1: read data valid.
- `imem_rdata_i` input DATA_WIDTH: instruction word.
- `instr_valid_o` output 1: `instr_o`/`pc_o` hold a valid instruction for decode.
- `instr_o` output DATA_WIDTH: fetched instruction.
- `pc_o` output DATA_WIDTH: address of `instr_o`.
- `stall_i` input 1: decode cannot accept `instr_o` this cycle.
- `br_valid_i` input 1: execute has resolved a branch or jump this cycle.
- `br_taken_i` input 1: the resolved branch or jump redirects the PC.
- `br_target_i` input DATA_WIDTH: redirect address.
- `flush_o` output 1: one-cycle pulse telling downstream stages to squash.
- `misaligned_o` output 1: one-cycle pulse for a misaligned redirect target.

## Operation
- **State machine:**
  - `BOOT`: idle for one cycle after reset.
  - `REQ`: request outstanding.
  - `WAIT`: granted, waiting for data.
  - `VALID`: instruction held for decode.
- **Internal registers:**
  - `pc_q`: next fetch address.
  - `fetch_pc_q`: address of the granted fetch.
  - `kill_q`: discard the next rvalid.
- **Reset values:** state `BOOT`, `pc_q`=BOOT_ADDR, `kill_q`=0, `imem_req_o`=0, `instr_valid_o`=0, `instr_o`=0, `pc_o`=BOOT_ADDR, `flush_o`=0, `misaligned_o`=0.
- **BOOT:** moves unconditionally to `REQ`.
- **REQ:** `imem_req_o`=1 (combinational from state). On `imem_gnt_i`: `fetch_pc_q`<=`pc_q`, `pc_q`<=`pc_q`+4 (modulo 2^DATA_WIDTH, wraps to 0), go to `WAIT`.
- **WAIT:** on `imem_rvalid_i`:
  - If `kill_q`=1: discard the data, clear `kill_q`, go to `REQ`.
  - Otherwise: register `instr_o`<=`imem_rdata_i`, `pc_o`<=`fetch_pc_q`, `instr_valid_o`<=1, go to `VALID`.
- **VALID:** hold `instr_o`/`pc_o` stable while `stall_i`=1. When `stall_i`=0, the instruction is consumed: `instr_valid_o`<=0, go to `REQ`. At most one fetch is in flight.
- **Redirect:** `br_valid_i`&`br_taken_i` in any state except `BOOT`:
  - `pc_q`<=`br_target_i`, `flush_o`<=1 for the next cycle, `instr_valid_o`<=0.
  - In `REQ` without gnt: stay in `REQ`; the new address appears next cycle. Changing the address of an ungranted request is legal.
  - In `REQ` with gnt in the same cycle: go to `WAIT` with `kill_q`<=1; `pc_q` takes the target, not +4.
  - In `WAIT` without rvalid: `kill_q`<=1, stay in `WAIT`.
  - In `WAIT` with rvalid in the same cycle: drop the data, `kill_q` stays 0, go to `REQ`.
  - In `VALID`: drop the held instruction, go to `REQ`.
- **Not taken:** `br_valid_i`&!`br_taken_i` has no effect.
- **During BOOT:** `br_valid_i` is ignored.
- **Reset mid-fetch:** all state is cleared and any later rvalid from the aborted fetch is not expected. The memory is reset with the core.

## Timing
- Reset deasserted at edge 0: `BOOT` in cycle 0, `imem_req_o`=1 in cycle 1.
- With gnt in cycle 1 and rvalid in cycle 2, `instr_valid_o`=1 in cycle 3.
- Latency from rvalid to `instr_valid_o`: 1 cycle. From consumption to the next `imem_req_o`: 1 cycle.
- Redirect sampled at edge N gives `flush_o`=1 and `imem_addr_o`=target in cycle N+1 (`REQ` case).
- `flush_o` and `misaligned_o` are registered, one cycle wide.

## Configuration
- `FETCH_MISALIGN_CHECK_EN`:
  - Defined: a taken redirect with `br_target_i[1:0]`≠0 does not redirect. `misaligned_o` pulses 1 the next cycle, `flush_o` stays 0, and sequential fetch continues.
  - Undefined: `br_target_i[1:0]` is forced to 00 on load and `misaligned_o` is tied to 0.

## Test plan
- **Boot:** reset, then release with gnt tied to 1 and rvalid one cycle after gnt, rdata=32'h00000013. Required: `imem_addr_o`=0, then 4, then 8. `instr_valid_o` is high with `pc_o`=0 in cycle 3.
- **Stall:** hold `stall_i`=1 for 5 cycles in `VALID`. Required: `instr_o`/`pc_o` stable and no `imem_req_o` until the cycle after `stall_i` falls.
- **Redirect in WAIT:** taken redirect to 32'h100 while in `WAIT`. Required: `flush_o` pulses once, the returning rdata never appears on `instr_o`, and the next request has address 32'h100.
- **Collisions:** redirect in the same cycle as gnt, and separately in the same cycle as rvalid. Required: no stale instruction and the next `pc_o` is 32'h100.
- **Wrap:** `pc_q`=32'hFFFF_FFFC, then a fetch. Required: the next `imem_addr_o` is 0.
- **Misaligned target:** target 32'h102 with the macro defined gives `misaligned_o`=1, no flush and a sequential address. With the macro undefined, the next address is 32'h100.
